// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scanner: scan states and
// active-low segment/anode patterns in {g,f,e,d,c,b,a} bit order.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        SCAN_ONES     = 2'd0,
        SCAN_TENS     = 2'd1,
        SCAN_HUNDREDS = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path
        // (here via the default arm) so no latch is inferred.
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes three BCD digits onto a 4-digit common-anode display with
// per-frame snapshots and a blanking guard. Optional: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_start
);

    localparam int               CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_VAL = CNT_W'(GUARD_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    scan_state_t      state_q, state_d;
    logic [3:0]       snap_h_q, snap_h_d;
    logic [3:0]       snap_t_q, snap_t_d;
    logic [3:0]       snap_o_q, snap_o_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic [3:0]       digit_sel;
    logic [6:0]       seg_dec;
    logic             blank;
    logic [1:0]       an_idx;

    always_comb begin
        tick          = (cnt_q == CNT_LAST);
        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        state_d       = state_q;
        snap_h_d      = snap_h_q;
        snap_t_d      = snap_t_q;
        snap_o_d      = snap_o_q;
        frame_start_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN_ONES: state_d = SCAN_TENS;
                SCAN_TENS: state_d = SCAN_HUNDREDS;
                SCAN_HUNDREDS: begin
                    state_d       = SCAN_ONES;
                    snap_h_d      = hundreds;
                    snap_t_d      = tens;
                    snap_o_d      = ones;
                    frame_start_d = 1'b1;
                end
                default: state_d = SCAN_ONES;
            endcase
        end
    end

    // Outputs are computed from the next-cycle values so the registered
    // an/seg line up with the state and counter after the same edge.
    always_comb begin
        case (state_d)
            SCAN_TENS: begin
                digit_sel = snap_t_d;
                an_idx    = 2'd1;
            end
            SCAN_HUNDREDS: begin
                digit_sel = snap_h_d;
                an_idx    = 2'd2;
            end
            default: begin
                digit_sel = snap_o_d;
                an_idx    = 2'd0;
            end
        endcase

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        case (state_d)
            SCAN_HUNDREDS: blank = (snap_h_d == 4'd0);
            SCAN_TENS:     blank = (snap_h_d == 4'd0) && (snap_t_d == 4'd0);
            default:       blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        seg_d = seg_dec;
        an_d  = ANODE_OFF;
        if (!blank && (cnt_d >= GUARD_VAL)) begin
            an_d[an_idx] = 1'b0;
        end
    end

    bcd_to_seg u_bcd_to_seg (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            state_q       <= SCAN_ONES;
            snap_h_q      <= 4'd0;
            snap_t_q      <= 4'd0;
            snap_o_q      <= 4'd0;
            an_q          <= ANODE_OFF;
            seg_q         <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            snap_h_q      <= snap_h_d;
            snap_t_q      <= snap_t_d;
            snap_o_q      <= snap_o_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = 1'b1;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (REFRESH_DIV=8, GUARD_CYCLES=2):
// directed steps plus random digits against a slot/frame arithmetic model.
module tb_seven_seg_scanner;

    localparam int RD    = 8;
    localparam int GC    = 2;
    localparam int FRAME = 3 * RD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hundreds = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_start;

    int         checks = 0;
    int         failures = 0;

    // Model state: edges since reset release and the digits latched at the
    // most recent frame boundary.
    int         k = 0;
    logic [3:0] m_h = 4'd0;
    logic [3:0] m_t = 4'd0;
    logic [3:0] m_o = 4'd0;

    always #5 clk = ~clk;

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hundreds    (hundreds),
        .tens        (tens),
        .ones        (ones),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_model();
        int         slot;
        int         pos;
        logic [3:0] digit;
        logic       blank;
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        logic       fs_exp;
        if (k == 0) begin
            an_exp  = 4'b1111;
            seg_exp = 7'b1111111;
            fs_exp  = 1'b0;
        end else begin
            slot  = (k / RD) % 3;
            pos   = k % RD;
            digit = (slot == 0) ? m_o : (slot == 1) ? m_t : m_h;
            blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (slot == 2) blank = (m_h == 4'd0);
            if (slot == 1) blank = (m_h == 4'd0) && (m_t == 4'd0);
`endif
            seg_exp = decode(digit);
            an_exp  = 4'b1111;
            if (pos >= GC && !blank) an_exp[slot] = 1'b0;
            fs_exp  = (k % FRAME == 0);
        end
        check("model_an", 32'(an), 32'(an_exp));
        check("model_seg", 32'(seg), 32'(seg_exp));
        check("model_dp", 32'(dp), 32'd1);
        check("model_frame_start", 32'(frame_start), 32'(fs_exp));
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        k++;
        if (k % FRAME == 0) begin
            m_h = hundreds;
            m_t = tens;
            m_o = ones;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) tick_cycle();
    endtask

    initial begin
        int low_cnt [4];
        int first_k;
        int pulses [$];

        // Reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        check_model();
        hundreds = 4'd1;
        tens     = 4'd2;
        ones     = 4'd3;
        rst_n    = 1'b1;

        // First frame shows the reset snapshot (000); 123 loads at its end.
        run(FRAME);
        check("load_123_frame_start", 32'(frame_start), 32'd1);
        check("load_123_ones_seg", 32'(seg), 32'(7'b0110000));
        check("guard_slot_start_an", 32'(an), 32'(4'b1111));

        // Each anode is low for RD-GC cycles of its slot; an[3] never.
        for (int i = 0; i < 4; i++) low_cnt[i] = 0;
        for (int c = 0; c < FRAME; c++) begin
            tick_cycle();
            for (int i = 0; i < 4; i++) if (an[i] == 1'b0) low_cnt[i]++;
        end
        check("an0_low_cycles", 32'(low_cnt[0]), 32'(RD - GC));
        check("an1_low_cycles", 32'(low_cnt[1]), 32'(RD - GC));
        check("an2_low_cycles", 32'(low_cnt[2]), 32'(RD - GC));
        check("an3_low_cycles", 32'(low_cnt[3]), 32'd0);

        // Mid-frame change during the tens slot stays invisible until the next frame.
        run(10);
        hundreds = 4'd4;
        tens     = 4'd5;
        ones     = 4'd6;
        run(8);
        check("midframe_hundreds_seg", 32'(seg), 32'(7'b1111001));
        check("midframe_hundreds_an", 32'(an), 32'(4'b1011));
        run(6);
        check("new_frame_pulse", 32'(frame_start), 32'd1);
        check("new_frame_ones_seg", 32'(seg), 32'(7'b0000010));

        // Invalid BCD ones digit shows a dash.
        ones = 4'hC;
        run(FRAME);
        check("dash_seg", 32'(seg), 32'(7'b0111111));
        run(GC);
        check("dash_an", 32'(an), 32'(4'b1110));

        // Leading zeros: 007.
        hundreds = 4'd0;
        tens     = 4'd0;
        ones     = 4'd7;
        run(FRAME - GC + RD + GC);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check("lz_tens_an", 32'(an), 32'(4'b1111));
`else
        check("lz_tens_an", 32'(an), 32'(4'b1101));
`endif
        check("lz_tens_seg", 32'(seg), 32'(7'b1000000));
        run(RD);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        check("lz_hundreds_an", 32'(an), 32'(4'b1111));
`else
        check("lz_hundreds_an", 32'(an), 32'(4'b1011));
`endif

        // Random digits changing at random cycles, including invalid codes.
        for (int c = 0; c < 6 * FRAME; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                hundreds = 4'($urandom_range(0, 15));
                tens     = 4'($urandom_range(0, 15));
                ones     = 4'($urandom_range(0, 15));
            end
            tick_cycle();
        end

        // Asynchronous reset in the middle of a tens slot.
        hundreds = 4'd9;
        tens     = 4'd8;
        ones     = 4'd7;
        for (int c = 0; c < FRAME && (k % FRAME) != (RD + 3); c++) tick_cycle();
        check("pre_reset_tens_an", 32'(an), 32'(4'b1101));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_an", 32'(an), 32'(4'b1111));
        check("async_reset_seg", 32'(seg), 32'(7'b1111111));
        check("async_reset_frame_start", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        k   = 0;
        m_h = 4'd0;
        m_t = 4'd0;
        m_o = 4'd0;
        check_model();
        rst_n = 1'b1;

        first_k = -1;
        for (int c = 0; c < 2 * RD && first_k < 0; c++) begin
            tick_cycle();
            if (an != 4'b1111) first_k = k;
        end
        check("post_reset_first_active_k", 32'(first_k), 32'(GC));
        check("post_reset_first_an", 32'(an), 32'(4'b1110));

        // frame_start spacing across three frames.
        for (int c = 0; c < 4 * FRAME && pulses.size() < 3; c++) begin
            tick_cycle();
            if (frame_start) pulses.push_back(k);
        end
        check("frame_pulse_count", 32'(pulses.size()), 32'd3);
        if (pulses.size() == 3) begin
            check("frame_period_1", 32'(pulses[1] - pulses[0]), 32'(FRAME));
            check("frame_period_2", 32'(pulses[2] - pulses[1]), 32'(FRAME));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
